// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the even-parity helper
// used by both the receive and transmit paths.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_t;

  // Parity bit that makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous Rx line; resets to the idle-high level.
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver with a valid/ready output register.
// Define UART_RX_PARITY_EN to add an even-parity bit, the parity_err pulse and byte discard.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx,
  output logic [7:0] databus_write,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IdxLast = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;
  logic ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic perr_pulse_q, perr_pulse_d;
`endif

  logic half_done, bit_done;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (Rx),
    .q_o   (rx_s)
  );

  assign half_done = (cnt_q == CntHalf);
  assign bit_done  = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rx_s) state_d = StStart;
      StStart: if (half_done) state_d = rx_s ? StIdle : StData;
      StData: begin
        if (bit_done && (idx_q == IdxLast)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (bit_done) state_d = StStop;
`endif
      // Leaving at mid-stop leaves half a bit of slack for the next start edge.
      StStop:  if (bit_done) state_d = rx_s ? StIdle : StBreak;
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    perr_pulse_d = 1'b0;
`endif
    if ((state_q == StIdle) || (state_d != state_q) || bit_done) begin
      cnt_d = '0;
    end
    unique case (state_q)
      StStart: begin
        if (half_done) begin
          idx_d = '0;
`ifdef UART_RX_PARITY_EN
          perr_d = 1'b0;
`endif
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_done && (rx_s != even_parity(shift_q))) perr_d = 1'b1;
      end
`endif
      StStop: begin
        if (bit_done) begin
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (perr_q) begin
            perr_pulse_d = 1'b1;
`endif
          end else if (!valid_q || ready) begin
            // An empty register, or one being consumed this cycle, takes the new byte.
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      perr_pulse_q <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      perr_pulse_q <= perr_pulse_d;
`endif
    end
  end

  assign databus_write = data_q;
  assign valid         = valid_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err    = perr_pulse_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are built from the line protocol and the
// delivered bytes and error pulses are compared with an expected-byte queue.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int T    = 10;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LATENCY = SYNC + C / 2 + (FRAME_BITS - 1) * C + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       Rx;
  logic       ready;
  logic [7:0] databus_write;
  logic       valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
`endif

  always #(T / 2) clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rx           (Rx),
    .databus_write(databus_write),
    .valid        (valid),
    .ready        (ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  // Monitor: handshakes, valid rises and error pulses, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         rise_q[$];
  int         fe_n = 0;
  int         ov_n = 0;
  int         pe_n = 0;
  logic       valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(databus_write);
    if (valid && !valid_prev) rise_q.push_back(cyc);
    valid_prev = valid;
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_n++;
`endif
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         rd = 0;
  int         t0, lat, rb, fe0, ov0, pe0;
  logic [7:0] b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_bytes(input string tag);
    chk({tag, " count"}, got_q.size() - rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd + i < got_q.size()) chk({tag, " byte"}, got_q[rd+i], exp_q[i]);
    end
    rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic snap();
    rb  = rise_q.size();
    fe0 = fe_n;
    ov0 = ov_n;
    pe0 = pe_n;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    Rx = 1'b0;
    #(C * T);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      #(C * T);
    end
`ifdef UART_RX_PARITY_EN
    Rx = (^d) ^ par_flip;
    #(C * T);
`endif
    Rx = stop_b;
    #(C * T);
  endtask

  task automatic phase_align();
    @(posedge clk);
    #($urandom_range(1, T - 1));
  endtask

  initial begin
    Rx    = 1'b1;
    ready = 1'b1;
    reset = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    #3 reset = 1'b0;
    #4;
    chk("reset databus", databus_write, 8'h00);
    chk("reset valid", valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset overrun", overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk("reset parity_err", parity_err, 1'b0);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back A5, 5A with ready held high; first frame also measures latency.
    snap();
    @(negedge clk);
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    lat = (rise_q.size() > rb) ? rise_q[rb] - t0 : 0;
    chk("pin-to-valid latency", lat, LATENCY);
    chk("b2b valid rises", rise_q.size() - rb, 2);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    compare_bytes("b2b");
    chk("b2b error pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);

    // Random bytes at random line phase with random idle gaps.
    snap();
    repeat (8) begin
      b = 8'($urandom);
      phase_align();
      #($urandom_range(0, 2) * C * T);
      send_frame(b, 1'b1);
      exp_q.push_back(b);
    end
    repeat (2 * C) @(negedge clk);
    compare_bytes("random");
    chk("random error pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);

    // Overrun: second byte arrives while the first is unconsumed.
    snap();
    @(posedge clk);
    #2 ready = 1'b0;
    phase_align();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    repeat (2 * C) @(negedge clk);
    chk("overrun pulses", ov_n - ov0, 1);
    chk("overrun databus kept", databus_write, 8'h3C);
    chk("overrun valid held", valid, 1'b1);
    chk("overrun valid rises", rise_q.size() - rb, 1);
    @(posedge clk);
    #2 ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("valid falls after consume", valid, 1'b0);
    exp_q.push_back(8'h3C);
    compare_bytes("overrun");
    chk("overrun frame_err", fe_n - fe0, 0);

    // Short glitch must be rejected as a false start.
    snap();
    phase_align();
    Rx = 1'b0;
    #(5 * T);
    Rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("glitch valid rises", rise_q.size() - rb, 0);
    chk("glitch error pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);
    b = 8'($urandom);
    phase_align();
    send_frame(b, 1'b1);
    exp_q.push_back(b);
    repeat (2 * C) @(negedge clk);
    compare_bytes("post-glitch");

    // Bad stop bit followed by a long break: one frame_err only.
    snap();
    phase_align();
    send_frame(8'h81, 1'b0);
    #(40 * C * T);
    Rx = 1'b1;
    #(C * T);
    chk("break frame_err pulses", fe_n - fe0, 1);
    chk("break valid rises", rise_q.size() - rb, 0);
    send_frame(8'h7E, 1'b1);
    exp_q.push_back(8'h7E);
    repeat (2 * C) @(negedge clk);
    compare_bytes("post-break");
    chk("post-break frame_err", fe_n - fe0, 1);

    // Reset in the middle of the data bits of FF; only the next byte is delivered.
    snap();
    phase_align();
    Rx = 1'b0;
    #(C * T);
    Rx = 1'b1;
    #(3 * C * T);
    reset = 1'b0;
    #(2 * T);
    chk("mid-frame reset valid", valid, 1'b0);
    chk("mid-frame reset databus", databus_write, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #(6 * C * T);
    phase_align();
    send_frame(8'h12, 1'b1);
    exp_q.push_back(8'h12);
    repeat (2 * C) @(negedge clk);
    compare_bytes("post-reset");
    chk("post-reset error pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity is discarded with one parity_err; correct parity is delivered.
    snap();
    par_flip = 1'b1;
    phase_align();
    send_frame(8'h07, 1'b1);
    repeat (2 * C) @(negedge clk);
    chk("parity_err pulses", pe_n - pe0, 1);
    chk("parity bad valid rises", rise_q.size() - rb, 0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    exp_q.push_back(8'h07);
    repeat (2 * C) @(negedge clk);
    compare_bytes("parity good");
    chk("parity good parity_err", pe_n - pe0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
